// File: rtl/uart_sim_pkg.sv
// Shared constants, state encodings and bit-period helper for the simulation UART bridge.
package uart_sim_pkg;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = FRAME_BITS - 2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_e;

  function automatic int unsigned calc_cpb(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sim_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_sim_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts the push.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/uart_sim_bridge.sv
// Simulation-side 8N1 UART: serializes host bytes to the SoC rx pin and
// deserializes the SoC tx pin into a show-ahead receive FIFO.
module uart_sim_bridge
  import uart_sim_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned UART_BAUD_RATE  = 9600,
  parameter int unsigned RX_FIFO_DEPTH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] host_tx_data,
  input  logic       host_tx_valid,
  output logic       host_tx_ready,
  output logic       soc_uart_rx,
  input  logic       soc_uart_tx,
  output logic [7:0] host_rx_data,
  output logic       host_rx_valid,
  input  logic       host_rx_ready,
  output logic       rx_overflow,
  output logic       rx_frame_error
);

  localparam int unsigned CPB   = calc_cpb(CLOCK_FREQUENCY, UART_BAUD_RATE);
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] MID_END  = CNT_W'(HALF - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_sim_bridge: clocks per bit must be at least 4");
  end
  if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_sim_bridge: RX_FIFO_DEPTH must be a power of 2 and at least 2");
  end

  // ---------------- transmit path ----------------
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_ready_q;
  logic             tx_bit_end;

  assign tx_bit_end    = (tx_cnt_q == BIT_END);
  assign host_tx_ready = tx_ready_q;
  assign soc_uart_rx   = tx_line_q;

  // Line value is computed with the next state so each bit starts on the edge that enters it.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_line_d = 1'b1;
        if (host_tx_valid) begin
          tx_state_d = TX_START;
          tx_shift_d = host_tx_data;
          tx_cnt_d   = '0;
          tx_line_d  = 1'b0;
        end
      end
      TX_START: begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end
      end
      TX_STOP: begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
        if (tx_bit_end) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = '0;
        tx_line_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      tx_ready_q <= (tx_state_d == TX_IDLE);
    end
  end

  // ---------------- receive path ----------------
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [1:0]       rx_sync_q;
  logic             rx_s;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;
  logic             rx_push, fifo_pop, fifo_empty, fifo_full;

  assign rx_s           = rx_sync_q[1];
  assign fifo_pop       = host_rx_ready && !fifo_empty;
  assign host_rx_valid  = !fifo_empty;
  assign rx_overflow    = ovf_q;
  assign rx_frame_error = ferr_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    ovf_d      = ovf_q;
    ferr_d     = ferr_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s) rx_state_d = RX_START;
      end
      RX_START: begin
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
        if (rx_cnt_q == MID_END) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          if (rx_s) begin
            rx_state_d = RX_IDLE;
            if (!fifo_full || fifo_pop) rx_push = 1'b1;
            else                        ovf_d   = 1'b1;
          end else begin
            rx_state_d = RX_WAIT_IDLE;
            ferr_d     = 1'b1;
          end
        end
      end
      RX_WAIT_IDLE: begin
        rx_cnt_d = '0;
        if (rx_s) rx_state_d = RX_IDLE;
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], soc_uart_tx};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
    end
  end

  uart_sim_fifo #(
    .WIDTH(8),
    .DEPTH(RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk    (clock),
    .rst_n  (reset),
    .push_i (rx_push),
    .pop_i  (fifo_pop),
    .data_i (rx_shift_q),
    .data_o (host_rx_data),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

endmodule
